alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_if.sv | 35 +++
 rtl/alu_arbiter.sv | 139 +++++++++++++
 2 files changed

// File: rtl/alu_arbiter_if.sv
// Requester/response bundle for the two-port shared-ALU arbiter.
// The master modport is the requester side; the slave modport is the arbiter.
interface alu_arbiter_if;
  logic        req0_valid;
  logic        req1_valid;
  logic        req0_ready;
  logic        req1_ready;
  logic [63:0] req0_a;
  logic [63:0] req0_b;
  logic [63:0] req1_a;
  logic [63:0] req1_b;
  logic [3:0]  req0_ctrl;
  logic [3:0]  req1_ctrl;
  logic        resp0_valid;
  logic        resp1_valid;
  logic        resp0_ready;
  logic        resp1_ready;
  logic [63:0] resp_w;
  logic        resp_zero;
  logic        busy;

  modport master (
    output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
           req0_ctrl, req1_ctrl, resp0_ready, resp1_ready,
    input  req0_ready, req1_ready, resp0_valid, resp1_valid,
           resp_w, resp_zero, busy
  );

  modport slave (
    input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
           req0_ctrl, req1_ctrl, resp0_ready, resp1_ready,
    output req0_ready, req1_ready, resp0_valid, resp1_valid,
           resp_w, resp_zero, busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two requesters share one 64-bit ALU; one operation in flight at a time.
// IDLE accepts a request, EXEC registers the ALU result, RESP holds it until consumed.
module alu_arbiter_alu (
  input  logic [3:0]  ctrl,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic [63:0] w,
  output logic        zero
);
  localparam logic [3:0] OP_AND   = 4'd0;
  localparam logic [3:0] OP_OR    = 4'd1;
  localparam logic [3:0] OP_ADD   = 4'd2;
  localparam logic [3:0] OP_SUB   = 4'd6;
  localparam logic [3:0] OP_PASSB = 4'd7;

  always_comb begin
    w = '0;
    case (ctrl)
      OP_AND:   w = a & b;
      OP_OR:    w = a | b;
      OP_ADD:   w = a + b;
      OP_SUB:   w = a - b;
      OP_PASSB: w = b;
      default:  w = '0;
    endcase
    zero = (w == 64'd0);
  end
endmodule

module alu_arbiter #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  alu_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  state_t      state_reg;
  logic        prio_reg;
  logic        grant_reg;
  logic        contend_reg;
  logic [63:0] op_a_reg;
  logic [63:0] op_b_reg;
  logic [3:0]  op_ctrl_reg;
  logic        resp0_valid_reg;
  logic        resp1_valid_reg;
  logic [63:0] resp_w_reg;
  logic        resp_zero_reg;
  logic        busy_reg;

  logic        both_req;
  logic        win1;
  logic        idle_ok;
  logic        take;
  logic        resp_done;
  logic [63:0] alu_w;
  logic        alu_zero;

  alu_arbiter_alu u_alu (
    .ctrl (op_ctrl_reg),
    .a    (op_a_reg),
    .b    (op_b_reg),
    .w    (alu_w),
    .zero (alu_zero)
  );

  // Port 1 wins when it is alone, or on contention when the pointer favours it.
  always_comb begin
    both_req       = bus.req0_valid & bus.req1_valid;
    win1           = bus.req1_valid & (~bus.req0_valid | (prio_reg & ~FIXED_PRIO));
    idle_ok        = ~reset & (state_reg == IDLE);
    bus.req0_ready = idle_ok & bus.req0_valid & ~win1;
    bus.req1_ready = idle_ok & win1;
    take           = bus.req0_ready | bus.req1_ready;
    resp_done      = grant_reg ? (resp1_valid_reg & bus.resp1_ready)
                               : (resp0_valid_reg & bus.resp0_ready);
  end

  assign bus.resp0_valid = resp0_valid_reg;
  assign bus.resp1_valid = resp1_valid_reg;
  assign bus.resp_w      = resp_w_reg;
  assign bus.resp_zero   = resp_zero_reg;
  assign bus.busy        = busy_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      prio_reg        <= 1'b0;
      grant_reg       <= 1'b0;
      contend_reg     <= 1'b0;
      op_a_reg        <= '0;
      op_b_reg        <= '0;
      op_ctrl_reg     <= '0;
      resp0_valid_reg <= 1'b0;
      resp1_valid_reg <= 1'b0;
      resp_w_reg      <= '0;
      resp_zero_reg   <= 1'b0;
      busy_reg        <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (take) begin
            op_a_reg    <= win1 ? bus.req1_a : bus.req0_a;
            op_b_reg    <= win1 ? bus.req1_b : bus.req0_b;
            op_ctrl_reg <= win1 ? bus.req1_ctrl : bus.req0_ctrl;
            grant_reg   <= win1;
            contend_reg <= both_req;
            busy_reg    <= 1'b1;
            state_reg   <= EXEC;
          end
        end
        EXEC: begin
          resp_w_reg      <= alu_w;
          resp_zero_reg   <= alu_zero;
          resp0_valid_reg <= ~grant_reg;
          resp1_valid_reg <= grant_reg;
          state_reg       <= RESP;
        end
        RESP: begin
          if (resp_done) begin
            resp0_valid_reg <= 1'b0;
            resp1_valid_reg <= 1'b0;
            busy_reg        <= 1'b0;
            state_reg       <= IDLE;
            // Rotate only if the other port was also waiting when this one won.
            if (!FIXED_PRIO && contend_reg) begin
              prio_reg <= ~grant_reg;
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end
endmodule
